// File: rtl/alu_muldiv_seq_pkg.sv
// rtl/alu_muldiv_seq_pkg.sv - shared ALU opcodes and sequencer state encoding
// Purpose: opcode constants of the execute-stage ALU and the FSM state type
//          of the multiply/divide sequencer.
// Ports:   none (package)
package alu_muldiv_seq_pkg;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_M_ITER = 3'd1,
    S_D_ABSA = 3'd2,
    S_D_ABSB = 3'd3,
    S_D_ITER = 3'd4,
    S_D_FIX  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/muldiv_counter.sv
// rtl/muldiv_counter.sv - 5-bit iteration counter with clear, enable and terminal flag
// Purpose: counts sequencer iterations; terminal is high on the last one.
// Ports:   clock, reset (async, active-high), clear, enable -> terminal
module muldiv_counter #(
  parameter int ITER = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [4:0] count;

  // Wrap past 31 is harmless: the FSM leaves the iterating state on terminal.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 5'd1;
    end
  end

  assign terminal = (count == 5'(ITER - 1));

endmodule

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - multi-cycle signed multiply/divide sequencer sharing the ALU
// Purpose: Booth radix-2 multiply and restoring divide, iterated through the
//          external combinational ALU; returns a 32-bit result and exception flag.
// Ports:   clock, reset (async, active-high)
//          ctrl_MULT, ctrl_DIV, data_operandA, data_operandB       - start + operands
//          data_result, data_exception, data_resultRDY             - result side
//          alu_operandA, alu_operandB, alu_opcode, alu_shamt       - to ALU
//          alu_result, alu_overflow, alu_isLessThan                - from ALU
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [WIDTH-1:0] alu_operandA,
  output logic [WIDTH-1:0] alu_operandB,
  output logic [4:0]       alu_opcode,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_isLessThan
);

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, next_state;
  logic [WIDTH-1:0] p_reg, q_reg, m_reg;   // P / remainder, Q / quotient, M / divisor
  logic             q_1, sign_q;
  logic             terminal, iterating, start, div_bad;

  logic             s_bit, mul_exc, d_lt;
  logic [WIDTH-1:0] m_p_next, m_q_next, r_shift;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign div_bad   = (data_operandB == '0) ||
                     ((data_operandA == INT_MIN) && (data_operandB == '1));
  assign iterating = (state == S_M_ITER) || (state == S_D_ITER);

  muldiv_counter #(.ITER(ITER)) u_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (start | ~iterating),
    .enable   (iterating),
    .terminal (terminal)
  );

  // Booth step: s is bit 32 of the true sum, so the arithmetic shift stays exact.
  assign s_bit    = alu_result[WIDTH-1] ^ alu_overflow;
  assign m_p_next = {s_bit, alu_result[WIDTH-1:1]};
  assign m_q_next = {alu_result[0], q_reg[WIDTH-1:1]};
  assign mul_exc  = (m_p_next != {WIDTH{m_q_next[WIDTH-1]}});

  // Restoring divide step: the ALU only gives a signed compare, so fix it up
  // to unsigned when the MSBs differ.
  assign r_shift = {p_reg[WIDTH-2:0], q_reg[WIDTH-1]};
  assign d_lt    = (r_shift[WIDTH-1] ^ m_reg[WIDTH-1]) ? m_reg[WIDTH-1] : alu_isLessThan;

  assign data_resultRDY = (state == S_DONE);
  assign alu_shamt      = '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    alu_opcode   = ALU_ADD;
    alu_operandA = '0;
    alu_operandB = '0;
    case (state)
      S_M_ITER: begin
        alu_operandA = p_reg;
        if (q_reg[0] != q_1) begin
          alu_operandB = m_reg;
          alu_opcode   = q_reg[0] ? ALU_SUB : ALU_ADD;
        end
        if (terminal) next_state = S_DONE;
      end
      S_D_ABSA: begin
        alu_operandB = q_reg;
        alu_opcode   = q_reg[WIDTH-1] ? ALU_SUB : ALU_ADD;
        next_state   = S_D_ABSB;
      end
      S_D_ABSB: begin
        alu_operandB = m_reg;
        alu_opcode   = m_reg[WIDTH-1] ? ALU_SUB : ALU_ADD;
        next_state   = S_D_ITER;
      end
      S_D_ITER: begin
        alu_operandA = r_shift;
        alu_operandB = m_reg;
        alu_opcode   = ALU_SUB;
        if (terminal) next_state = S_D_FIX;
      end
      S_D_FIX: begin
        alu_operandB = q_reg;
        alu_opcode   = sign_q ? ALU_SUB : ALU_ADD;
        next_state   = S_DONE;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    // A start in any state overrides the current operation.
    if (ctrl_MULT && ctrl_DIV) begin
      next_state = S_DONE;
    end else if (ctrl_MULT) begin
      next_state = S_M_ITER;
    end else if (ctrl_DIV) begin
      next_state = div_bad ? S_DONE : S_D_ABSA;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_reg          <= '0;
      q_reg          <= '0;
      m_reg          <= '0;
      q_1            <= 1'b0;
      sign_q         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      p_reg          <= '0;
      q_reg          <= data_operandA;
      m_reg          <= data_operandB;
      q_1            <= 1'b0;
      sign_q         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      data_result    <= '0;
      data_exception <= (ctrl_MULT && ctrl_DIV) || (!ctrl_MULT && div_bad);
    end else begin
      case (state)
        S_M_ITER: begin
          p_reg <= m_p_next;
          q_reg <= m_q_next;
          q_1   <= q_reg[0];
          if (terminal) begin
            data_result    <= m_q_next;
            data_exception <= mul_exc;
          end
        end
        S_D_ABSA: q_reg <= alu_result;
        S_D_ABSB: m_reg <= alu_result;
        S_D_ITER: begin
          p_reg <= d_lt ? r_shift : alu_result;
          q_reg <= {q_reg[WIDTH-2:0], ~d_lt};
        end
        S_D_FIX: begin
          data_result    <= alu_result;
          data_exception <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
